// File: rtl/softmax_pkg.sv
// Shared widths, state encoding and exponent-to-fixed conversion for the
// softmax normalisation stage.
package softmax_pkg;
   localparam int EXP_W  = 21;
   localparam int POS_W  = 5;
   localparam int MANT_W = 16;
   localparam int FIX_W  = 32;
   localparam int SUM_W  = 36;
   localparam int PROB_W = 16;

   typedef enum logic [1:0] {S_LOAD, S_DIV, S_OUT} norm_state_t;

   // m * 2^(p-16) as unsigned 16.16; positions above 16 clamp to 16
   function automatic logic [FIX_W-1:0] exp_to_fix(input logic [EXP_W-1:0] e);
      logic [POS_W-1:0] p;
      p = e[EXP_W-1:MANT_W];
      if (p > 5'd16) p = 5'd16;
      return FIX_W'(e[MANT_W-1:0]) << p;
   endfunction
endpackage

// File: rtl/sm_restoring_div.sv
// Serial restoring divider: one load cycle then Q_W iterations, quotient
// saturates to all-ones when it would not fit in Q_W bits.
module sm_restoring_div #(
   parameter int Q_W   = 16,
   parameter int DVD_W = 48,
   parameter int DVS_W = 36
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             done,
   output logic [Q_W-1:0]   quotient
);
   localparam int CNT_W = $clog2(Q_W);

   logic             running;
   logic             sat;
   logic [DVS_W-1:0] rem;
   logic [DVS_W-1:0] dvs;
   logic [Q_W-1:0]   lo;
   logic [Q_W-1:0]   q;
   logic [CNT_W-1:0] it;
   logic [DVS_W:0]   trial;
   logic             take;
   logic [DVS_W-1:0] hi_part;

   // The upper dividend bits are the starting remainder; the quotient only
   // overflows when they already reach the divisor.
   assign hi_part  = DVS_W'(dividend[DVD_W-1:Q_W]);
   assign trial    = {rem, lo[Q_W-1]};
   assign take     = trial >= {1'b0, dvs};
   assign done     = (start && divisor == '0) || (running && it == CNT_W'(Q_W-1));
   assign quotient = sat ? '1 : q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         sat     <= 1'b0;
         rem     <= '0;
         dvs     <= '0;
         lo      <= '0;
         q       <= '0;
         it      <= '0;
      end else if (start) begin
         dvs     <= divisor;
         rem     <= hi_part;
         lo      <= dividend[Q_W-1:0];
         q       <= '0;
         it      <= '0;
         sat     <= (divisor != '0) && (hi_part >= divisor);
         running <= divisor != '0;
      end else if (running) begin
         rem <= take ? DVS_W'(trial - {1'b0, dvs}) : trial[DVS_W-1:0];
         lo  <= lo << 1;
         q   <= {q[Q_W-2:0], take};
         it  <= it + 1'b1;
         if (it == CNT_W'(Q_W-1)) running <= 1'b0;
      end
   end
endmodule

// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers one vector of exponent words, sums them and
// streams out each element divided by the sum as a Q0.16 probability.
module softmax_norm
   import softmax_pkg::*;
#(
   parameter int N_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROB_W-1:0] out_prob,
   output logic              out_last,
   output logic              busy,
   output logic              err_len
);
   localparam int CNT_W = $clog2(N_MAX + 1);
   localparam int IDX_W = $clog2(N_MAX);

   norm_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [SUM_W-1:0]  sum;
   logic [FIX_W-1:0]  buf_mem [N_MAX];
   logic              rdy_en;
   logic              div_started;
   logic              div_start;
   logic              div_done;
   logic [PROB_W-1:0] div_q;
   logic [FIX_W-1:0]  in_fix;
   logic              in_hs;
   logic              vec_end;

   assign in_fix    = exp_to_fix(in_exp);
   assign in_ready  = rdy_en && state == S_LOAD;
   assign in_hs     = in_valid && in_ready;
   assign vec_end   = in_last || cnt == CNT_W'(N_MAX - 1);
   assign out_valid = state == S_OUT;
   assign out_last  = out_valid && (CNT_W'(idx) == cnt - 1'b1);
   assign out_prob  = out_valid ? div_q : '0;
   assign busy      = state != S_LOAD || cnt != '0;
   // One divider launch per visit to S_DIV; the quotient stays put through S_OUT.
   assign div_start = state == S_DIV && !div_started;

   sm_restoring_div #(
      .Q_W   (PROB_W),
      .DVD_W (FIX_W + PROB_W),
      .DVS_W (SUM_W)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend ({buf_mem[idx], {PROB_W{1'b0}}}),
      .divisor  (sum),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk) begin
      if (in_hs) buf_mem[cnt[IDX_W-1:0]] <= in_fix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_LOAD;
         cnt         <= '0;
         idx         <= '0;
         sum         <= '0;
         rdy_en      <= 1'b0;
         div_started <= 1'b0;
         err_len     <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         case (state)
            S_LOAD: if (in_hs) begin
               sum <= sum + SUM_W'(in_fix);
               cnt <= cnt + 1'b1;
               if (vec_end) begin
                  state       <= S_DIV;
                  idx         <= '0;
                  div_started <= 1'b0;
                  if (!in_last) err_len <= 1'b1;
               end
            end
            S_DIV: begin
               if (div_start) div_started <= 1'b1;
               if (div_done) begin
                  state       <= S_OUT;
                  div_started <= 1'b0;
               end
            end
            S_OUT: if (out_ready) begin
               if (out_last) begin
                  state <= S_LOAD;
                  cnt   <= '0;
                  sum   <= '0;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_DIV;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_softmax_norm.sv
// Randomised bench for softmax_norm against an arithmetic reference model.
module tb_softmax_norm;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic [20:0] in_exp = '0;
   logic        in_ready, out_valid, out_last, busy, err_len;
   logic [15:0] out_prob;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [20:0] vec [16];
   int vlen;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   softmax_norm #(.N_MAX(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_exp(in_exp), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_prob(out_prob), .out_last(out_last),
      .busy(busy), .err_len(err_len)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic longint fixv(input logic [20:0] e);
      int p;
      p = int'(e[20:16]);
      if (p > 16) p = 16;
      return longint'(e[15:0]) * (longint'(1) << p);
   endfunction

   function automatic longint ref_q(input longint v, input longint s);
      longint q;
      if (s == 0) return 0;
      q = (v * 65536) / s;
      return (q > 65535) ? 65535 : q;
   endfunction

   // called at a negedge; returns at the negedge after the handshake edge
   task automatic push(input logic [20:0] e, input bit last);
      int t = 0;
      in_valid = 1'b1; in_exp = e; in_last = last;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("in_timeout", 64'(0), 64'(1));
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic run_vec(input bit trunc, input int stall_at);
      longint s = 0;
      int ref_cyc, t;
      logic [15:0] hp;
      logic hl;
      for (int i = 0; i < vlen; i++) s += fixv(vec[i]);
      for (int i = 0; i < vlen; i++) push(vec[i], !trunc && i == vlen - 1);
      ref_cyc = cyc;
      chk("rdy_drop", 64'(in_ready), 64'(0));
      chk("busy_div", 64'(busy), 64'(1));
      if (trunc) chk("err_len_set", 64'(err_len), 64'(1));
      for (int i = 0; i < vlen; i++) begin
         t = 0;
         while (!out_valid && t < 40) begin @(negedge clk); t++; end
         chk("latency", 64'(cyc - ref_cyc), 64'((s == 0) ? 1 : 17));
         chk("prob", 64'(out_prob), 64'(ref_q(fixv(vec[i]), s)));
         chk("last", 64'(out_last), 64'(i == vlen - 1));
         if (i == stall_at) begin
            hp = out_prob; hl = out_last;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("stall_vld", 64'(out_valid), 64'(1));
               chk("stall_prob", 64'(out_prob), 64'(hp));
               chk("stall_last", 64'(out_last), 64'(hl));
            end
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         ref_cyc = cyc;
         if (i < vlen - 1) chk("vld_drop", 64'(out_valid), 64'(0));
      end
      chk("rdy_back", 64'(in_ready), 64'(1));
      chk("idle", 64'(busy), 64'(0));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_prob", 64'(out_prob), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err_len", 64'(err_len), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", 64'(in_ready), 64'(1));

      vlen = 1; vec[0] = {5'd16, 16'd1};
      run_vec(1'b0, -1);
      vlen = 2; vec[0] = {5'd16, 16'd1}; vec[1] = {5'd16, 16'd1};
      run_vec(1'b0, -1);
      vlen = 2; vec[0] = {5'd16, 16'd1}; vec[1] = {5'd16, 16'd3};
      run_vec(1'b0, 0);
      vlen = 2; vec[0] = {5'd3, 16'd0}; vec[1] = {5'd20, 16'd0};
      run_vec(1'b0, -1);

      repeat (25) begin
         vlen = int'($urandom_range(1, 16));
         for (int i = 0; i < vlen; i++)
            vec[i] = {5'($urandom_range(0, 31)),
                      ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4))
                                                  : 16'($urandom)};
         run_vec(1'b0, int'($urandom_range(0, 16)));
      end
      chk("err_len_clear", 64'(err_len), 64'(0));

      vlen = 16;
      for (int i = 0; i < 16; i++) vec[i] = {5'($urandom_range(0, 20)), 16'($urandom)};
      run_vec(1'b1, -1);
      chk("err_len_sticky", 64'(err_len), 64'(1));

      push({5'd16, 16'd1}, 1'b1);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 64'(out_valid), 64'(0));
      chk("mid_rst_prob", 64'(out_prob), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_rdy", 64'(in_ready), 64'(0));
      chk("mid_rst_err", 64'(err_len), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vlen = 1; vec[0] = {5'd16, 16'd2};
      run_vec(1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/softmax_norm.md
# softmax_norm

Sequential normalisation stage directly downstream of the combinational exponent approximator. It collects one softmax vector of packed exponent words and converts each word to unsigned 16.16 fixed point. It keeps a running sum, then streams out each element divided by that sum as a Q0.16 probability. A single shared serial restoring divider produces the quotients.

## Interface
- `N_MAX`, 16: maximum vector length (entries buffered).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  stage can accept a word.
- `in_exp`  in  21  packed exponent: [20:16] position p, [15:0] mantissa m.
- `in_last`  in  1  final element of current vector.
- `out_valid`  out  1  probability valid.
- `out_ready`  in  1  consumer accepts.
- `out_prob`  out  16  Q0.16 probability.
- `out_last`  out  1  final probability of vector.
- `busy`  out  1  high outside S_LOAD, or when S_LOAD holds ≥1 element.
- `err_len`  out  1  sticky flag, set on vector truncation; cleared only by reset.

## Operation
- Value encoded by `in_exp` is m × 2^(p−16).
  - Fixed conversion: v = m << p, 32-bit unsigned 16.16.
  - p > 16 clamps to 16.
- FSM states S_LOAD, S_DIV, S_OUT.
- S_LOAD:
  - `in_ready`=1.
  - Each handshake stores v in buf[cnt], adds v to 36-bit `sum`, and increments cnt.
  - Handshake with `in_last`=1 → S_DIV, idx=0.
  - Handshake when cnt = N_MAX−1 with `in_last`=0: the element is stored, treated as last, `err_len`←1, → S_DIV.
- S_DIV:
  - `in_ready`=0.
  - Divider computes q = floor(buf[idx] × 2^16 / sum) by restoring division: 1 load cycle, then 16 iteration cycles.
  - Result saturates to 16'hFFFF if ≥ 2^16, which occurs when buf[idx] = sum.
  - sum = 0 → q = 0, no iterations.
  - → S_OUT.
- S_OUT:
  - `out_valid`=1, `out_prob`=q, `out_last`=(idx = cnt−1).
  - Outputs held stable until `out_ready`.
  - On handshake: if last, clear cnt and sum and go to S_LOAD; else idx+1 → S_DIV.
- Reset values:
  - `in_ready` 0 during reset, 1 from the first clock after deassertion.
  - `out_valid` 0, `out_prob` 0, `out_last` 0, `busy` 0, `err_len` 0.
  - State S_LOAD, cnt/idx/sum 0.
- Reset asserted mid-vector or mid-division: all state discarded immediately (async). No output is produced for the partial vector.

## Timing
- Input throughput: one word per cycle in S_LOAD.
- From `in_last` handshake at edge T, the first `out_valid` rises at T+17. That is 1 load cycle + 16 iterations; S_OUT is entered on the 17th edge.
- Per subsequent element: 17 cycles from the previous output handshake to the next `out_valid`.
- sum = 0: `out_valid` at T+1 after entering S_DIV.
- `in_ready` falls the cycle after the last handshake and returns the cycle after the `out_last` handshake. No overlap between vectors.
- `out_valid` never deasserts without handshake; no combinational path from `out_ready` to `in_ready`.

## Structure
- Package `softmax_pkg`:
  - EXP_W=21, POS_W=5, MANT_W=16, FIX_W=32, SUM_W=36, PROB_W=16.
  - State enum `norm_state_t` {S_LOAD, S_DIV, S_OUT}.
- Sub-module `sm_restoring_div`:
  - Inputs: start, 48-bit dividend, 36-bit divisor.
  - Outputs: done pulse, 16-bit saturated quotient.
  - Parameterised on quotient width.
- Top: FSM, buffer array, accumulator, length counter.

## Test plan
- Single element {5'd16,16'd1} with `in_last` → one output 16'hFFFF, `out_last`=1, `out_valid` at T+17.
- Two elements, both {5'd16,16'd1} → 16'h8000, 16'h8000; `out_last` only on second.
- Elements 1.0 ({16,1}) and 3.0 ({16,3}) → 16'h4000 then 16'hC000.
- 16 elements with `in_last` never asserted → `err_len`=1 after 16th handshake; 16 outputs, `out_last` on 16th.
- `out_ready` held low 5 cycles during S_OUT → `out_prob`/`out_last` stable, no extra divider start.
- `rst_n` pulsed low at iteration 8 of first division → outputs zero; next vector {16,2} alone yields 16'hFFFF.
